// File: rtl/write_bank_pkg.sv
// Shared types and defaults for the write-bank serializer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   DEF_LANES / DEF_DEPTH / DEF_DATA_W : default geometry of the bank
//   state_t                            : drain FSM state encoding
//   wrap_inc()                         : row address increment modulo depth
package write_bank_pkg;

    localparam int DEF_LANES  = 10;
    localparam int DEF_DEPTH  = 512;
    localparam int DEF_DATA_W = 8;

    // Drain sequencer states:
    //   IDLE   - waiting for a start request
    //   RD     - issue the row read to every lane RAM (stalls while a write owns the port)
    //   CAP    - RAM outputs valid, copy them into the row buffer
    //   STREAM - emit the row buffer one lane per handshake
    //   FIN    - one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        CAP    = 3'd2,
        STREAM = 3'd3,
        FIN    = 3'd4
    } state_t;

    // Next row address; the bank need not be a power of two deep, so the
    // wrap is explicit rather than relying on counter overflow.
    function automatic int wrap_inc(input int addr, input int depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// Single-port lane RAM, DEPTH x DATA_W, write-enable plus read-enable.
// Latency: synchronous read, rdata valid the cycle after re=1.
// Backpressure: none; the caller guarantees we and re are never both set.
//
// Ports:
//   clk           : clock, posedge
//   we / re       : write enable / read enable (mutually exclusive)
//   addr          : shared row address for read or write
//   wdata / rdata : write data in / registered read data out
module bank_ram #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    // Storage carries no reset so contents survive a reset of the sequencer.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/write_bank_serializer.sv
// Parallel-write lane bank drained row by row into a serial byte stream.
// Latency: start -> first out_valid 3 cycles; 2-cycle bubble between rows.
// Backpressure: out_ready low holds out_data/out_last stable; a write in RD stalls the read.
//
// Ports:
//   clk, rst_n                           : clock and synchronous active-low reset
//   wr_en, wr_addr, wr_mask, wr_data     : masked parallel row write (one element per lane)
//   start, start_addr, row_count         : drain request (row_count=0 completes immediately)
//   out_valid, out_ready, out_data, out_last : serial stream, lane 0 first
//   busy, done                           : drain in progress / one-cycle completion pulse
module write_bank_serializer
    import write_bank_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [LANES-1:0]              wr_mask,
    input  logic [LANES-1:0][DATA_W-1:0]  wr_data,
    input  logic                          start,
    input  logic [AW-1:0]                 start_addr,
    input  logic [CW-1:0]                 row_count,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int LIW = $clog2(LANES);

    state_t                          state;
    state_t                          state_nxt;

    logic [LANES-1:0][DATA_W-1:0]    row_buf;
    logic [LANES-1:0][DATA_W-1:0]    ram_rdata;
    logic [LIW-1:0]                  lane_idx;
    logic [AW-1:0]                   row_addr;
    logic [CW-1:0]                   rows_left;   // rows still to emit, including the current one

    logic                            rd_en;
    logic [AW-1:0]                   ram_addr;
    logic                            last_lane;
    logic                            more_rows;
    logic [AW-1:0]                   row_addr_nxt;

    // ------------------------------------------------------------------
    // Lane RAMs: a write always owns the single port; the read is only
    // issued in RD when no write is pending that cycle.
    // ------------------------------------------------------------------
    assign rd_en    = (state == RD) && !wr_en;
    assign ram_addr = wr_en ? wr_addr : row_addr;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bank_ram #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_bank_ram (
            .clk    (clk),
            .we     (wr_en & wr_mask[i]),
            .re     (rd_en),
            .addr   (ram_addr),
            .wdata  (wr_data[i]),
            .rdata  (ram_rdata[i])
        );
    end

    assign last_lane    = (lane_idx == LIW'(LANES - 1));
    assign more_rows    = (rows_left > CW'(1));
    assign row_addr_nxt = AW'(wrap_inc(int'(row_addr), DEPTH));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (row_count != '0) ? RD : FIN;
                end
            end
            RD: begin
                // A concurrent write holds us here until the port is free.
                if (!wr_en) begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (out_ready && last_lane) begin
                    state_nxt = more_rows ? RD : FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all decoded from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            RD, CAP: begin
                busy = 1'b1;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Data comes straight from the row buffer, so it can only change on a
    // handshake or in CAP; that keeps it stable under backpressure.
    assign out_data = row_buf[lane_idx];
    assign out_last = (state == STREAM) && last_lane && !more_rows;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_buf   <= '0;
            lane_idx  <= '0;
            row_addr  <= '0;
            rows_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (row_count != '0)) begin
                        row_addr  <= start_addr;
                        rows_left <= row_count;
                    end
                end
                CAP: begin
                    // Snapshot the whole row; later writes to this address
                    // only land in the RAM, never in the buffer.
                    row_buf  <= ram_rdata;
                    lane_idx <= '0;
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last_lane) begin
                            lane_idx <= '0;
                            if (more_rows) begin
                                rows_left <= rows_left - CW'(1);
                                row_addr  <= row_addr_nxt;
                            end else begin
                                rows_left <= '0;
                            end
                        end else begin
                            lane_idx <= lane_idx + LIW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_bank_serializer.sv
module tb_write_bank_serializer;

    localparam int LANES  = 4;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic                         clk;
    logic                         rst_n;
    logic                         wr_en;
    logic [2:0]                   wr_addr;
    logic [LANES-1:0]             wr_mask;
    logic [LANES-1:0][DATA_W-1:0] wr_data;
    logic                         start;
    logic [2:0]                   start_addr;
    logic [3:0]                   row_count;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    logic                         out_last;
    logic                         busy;
    logic                         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Captured results of the most recent drain
    logic [7:0] got_data[$];
    int         got_cyc[$];
    logic       got_last[$];
    logic [7:0] stall_q[$];
    logic       stall_last_q[$];
    int         done_cyc;
    int         done_cnt;
    int         vld_cnt;
    logic       busy_c1;
    logic       busy_after;
    logic       timed_out;

    write_bank_serializer #(
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .row_count  (row_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [2:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_mask = m;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_mask = 4'h0;
    endtask

    // Start a drain in cycle 0 and record every accepted beat with its cycle.
    // stall_beat/stall_n: hold out_ready low for stall_n cycles when beat stall_beat is offered.
    // wr_c0/wr_nc/wa/wd : full-mask write driven during cycles [wr_c0, wr_c0+wr_nc).
    // rs_cyc            : cycle in which a second (to be ignored) start is pulsed.
    task automatic drain(input logic [2:0] a, input logic [3:0] n,
                         input int stall_beat, input int stall_n,
                         input int wr_c0, input int wr_nc,
                         input logic [2:0] wa, input logic [31:0] wd,
                         input int rs_cyc);
        int   cyc;
        int   beats;
        int   held;
        logic fin_loop;
        cyc = 0; beats = 0; held = 0; fin_loop = 1'b0;
        got_data.delete(); got_cyc.delete(); got_last.delete();
        stall_q.delete(); stall_last_q.delete();
        done_cyc = -1; done_cnt = 0; vld_cnt = 0;
        busy_c1 = 1'b0; busy_after = 1'b1; timed_out = 1'b0;
        start      = 1'b1;
        start_addr = a;
        row_count  = n;
        out_ready  = 1'b1;
        wr_addr    = wa;
        wr_data    = wd;
        wr_mask    = 4'hF;
        wr_en      = (cyc >= wr_c0) && (cyc < wr_c0 + wr_nc);
        while (!fin_loop) begin
            tick();
            cyc++;
            start = 1'b0;
            if (cyc == rs_cyc) begin
                start      = 1'b1;
                start_addr = a + 3'd1;
                row_count  = 4'd1;
            end
            wr_en = (cyc >= wr_c0) && (cyc < wr_c0 + wr_nc);
            if (cyc == 1) busy_c1 = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                fin_loop   = 1'b1;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    vld_cnt++;
                    if (beats == stall_beat && held < stall_n) begin
                        out_ready = 1'b0;
                        held++;
                        stall_q.push_back(out_data);
                        stall_last_q.push_back(out_last);
                    end else begin
                        got_data.push_back(out_data);
                        got_cyc.push_back(cyc);
                        got_last.push_back(out_last);
                        beats++;
                    end
                end
                if (cyc >= 200) begin
                    timed_out = 1'b1;
                    fin_loop  = 1'b1;
                end
            end
        end
        wr_en     = 1'b0;
        wr_mask   = 4'h0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_row();
        logic [31:0] row;
        row = 32'h13121110;
        write_row(3'd2, 4'hF, row);
        drain(3'd2, 4'd1, -1, 0, -1, 0, 3'd0, 32'h0, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: drain did not complete"); end
        n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b expected 1", busy_c1); end
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL single_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== row[8*i +: 8]) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", i, got_data[i], row[8*i +: 8]); end
            n_checks++; if (got_cyc[i] !== 3 + i) begin n_fail++; $display("FAIL single_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 3 + i); end
            n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
        end
        n_checks++; if (done_cyc !== 7) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 7", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_width: got %0d expected 1", done_cnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy_after); end
    endtask

    // Rows 7 then 0 (address wrap), with a second start pulsed in RD that must be ignored.
    task automatic test_wrap();
        logic [63:0] exp_rows;
        int          exp_c;
        write_row(3'd7, 4'hF, 32'h73727170);
        write_row(3'd0, 4'hF, 32'hA3A2A1A0);
        exp_rows = 64'hA3A2A1A0_73727170;
        drain(3'd7, 4'd2, -1, 0, -1, 0, 3'd0, 32'h0, 7);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: drain did not complete"); end
        n_checks++; if (got_data.size() !== 8) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 8", got_data.size()); end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            exp_c = (i < 4) ? 3 + i : 5 + i;
            n_checks++; if (got_data[i] !== exp_rows[8*i +: 8]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i], exp_rows[8*i +: 8]); end
            n_checks++; if (got_cyc[i] !== exp_c) begin n_fail++; $display("FAIL wrap_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], exp_c); end
            n_checks++; if (got_last[i] !== (i == 7)) begin n_fail++; $display("FAIL wrap_last[%0d]: got %b expected %b", i, got_last[i], (i == 7)); end
        end
        n_checks++; if (done_cyc !== 13) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected 13", done_cyc); end
    endtask

    task automatic test_mask();
        logic [31:0] exp_row;
        exp_row = 32'h00FF00FF;
        write_row(3'd4, 4'hF, 32'h00000000);
        write_row(3'd4, 4'b0101, 32'hFFFFFFFF);
        drain(3'd4, 4'd1, -1, 0, -1, 0, 3'd0, 32'h0, -1);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL mask_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_row[8*i +: 8]) begin n_fail++; $display("FAIL mask_data[%0d]: got %h expected %h", i, got_data[i], exp_row[8*i +: 8]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] row;
        row = 32'h53525150;
        write_row(3'd5, 4'hF, row);
        drain(3'd5, 4'd1, 1, 5, -1, 0, 3'd0, 32'h0, -1);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL bp_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== row[8*i +: 8]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], row[8*i +: 8]); end
        end
        n_checks++; if (stall_q.size() !== 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_q.size()); end
        for (int i = 0; i < stall_q.size(); i++) begin
            n_checks++; if (stall_q[i] !== 8'h51 || stall_last_q[i] !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got data %h last %b expected 51/0", i, stall_q[i], stall_last_q[i]); end
        end
        if (got_cyc.size() == 4) begin
            n_checks++; if (got_cyc[3] !== 11) begin n_fail++; $display("FAIL bp_last_cycle: got %0d expected 11", got_cyc[3]); end
        end
        n_checks++; if (done_cyc !== 12) begin n_fail++; $display("FAIL bp_done_cycle: got %0d expected 12", done_cyc); end
    endtask

    // Writes to the drained row during RD for 3 cycles stall the read and are visible in the drain.
    task automatic test_write_during_rd();
        logic [31:0] new_row;
        new_row = 32'hC3C2C1C0;
        write_row(3'd3, 4'hF, 32'h33323130);
        drain(3'd3, 4'd1, -1, 0, 1, 3, 3'd3, new_row, -1);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL wrd_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== new_row[8*i +: 8]) begin n_fail++; $display("FAIL wrd_data[%0d]: got %h expected %h", i, got_data[i], new_row[8*i +: 8]); end
        end
        if (got_cyc.size() > 0) begin
            n_checks++; if (got_cyc[0] !== 6) begin n_fail++; $display("FAIL wrd_first_cycle: got %0d expected 6", got_cyc[0]); end
        end
        n_checks++; if (done_cyc !== 10) begin n_fail++; $display("FAIL wrd_done_cycle: got %0d expected 10", done_cyc); end
    endtask

    // A write during STREAM to the captured row must not disturb the buffer, but must land in RAM.
    task automatic test_capture_isolation();
        logic [31:0] old_row;
        logic [31:0] new_row;
        old_row = 32'h63626160;
        new_row = 32'hE3E2E1E0;
        write_row(3'd6, 4'hF, old_row);
        drain(3'd6, 4'd1, -1, 0, 4, 1, 3'd6, new_row, -1);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL iso_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== old_row[8*i +: 8]) begin n_fail++; $display("FAIL iso_data[%0d]: got %h expected %h", i, got_data[i], old_row[8*i +: 8]); end
        end
        drain(3'd6, 4'd1, -1, 0, -1, 0, 3'd0, 32'h0, -1);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== new_row[8*i +: 8]) begin n_fail++; $display("FAIL iso_new_data[%0d]: got %h expected %h", i, got_data[i], new_row[8*i +: 8]); end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] row2;
        row2 = 32'h13121110;
        start      = 1'b1;
        start_addr = 3'd0;
        row_count  = 4'd2;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_streaming: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out_data: got %h expected 00", out_data); end
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stays_idle: got busy %b valid %b expected 0/0", busy, out_valid); end
        // RAM survives reset and the lane index starts again at 0.
        drain(3'd2, 4'd1, -1, 0, -1, 0, 3'd0, 32'h0, -1);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL rst_ram_beats: got %0d expected 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== row2[8*i +: 8]) begin n_fail++; $display("FAIL rst_ram_data[%0d]: got %h expected %h", i, got_data[i], row2[8*i +: 8]); end
        end
    endtask

    task automatic test_zero_count();
        drain(3'd5, 4'd0, -1, 0, -1, 0, 3'd0, 32'h0, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: drain did not complete"); end
        n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_width: got %0d expected 1", done_cnt); end
        n_checks++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL zero_out_valid: got %0d valid cycles expected 0", vld_cnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b expected 0", busy_after); end
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_mask    = 4'h0;
        wr_data    = '0;
        start      = 1'b0;
        start_addr = 3'd0;
        row_count  = 4'd0;
        out_ready  = 1'b1;
        #2;
        test_reset();
        test_single_row();
        test_wrap();
        test_mask();
        test_backpressure();
        test_write_during_rd();
        test_capture_isolation();
        test_reset_mid_stream();
        test_zero_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_bank_serializer.md
WRITE_BANK_SERIALIZER -- requirements
Module: write_bank_serializer

Interface
REQ-001 SHALL have parameter LANES, default 10, number of parallel byte lanes (>=2).
REQ-002 SHALL have parameter DEPTH, default 512, rows per lane (>=2, need not be a power of two).
REQ-003 SHALL have parameter DATA_W, default 8, bits per lane element.
REQ-004 SHALL have port clk  in  1  clock; all logic posedge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports wr_en  in  1, wr_addr  in  clog2(DEPTH), wr_mask  in  LANES, wr_data  in  LANES x DATA_W; parallel row write.
REQ-007 SHALL have ports start  in  1, start_addr  in  clog2(DEPTH), row_count  in  clog2(DEPTH)+1; drain request.
REQ-008 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  DATA_W, out_last  out  1; serial stream.
REQ-009 SHALL have ports busy  out  1 (drain in progress) and done  out  1 (single-cycle completion pulse).

Function
REQ-010 Write: when wr_en=1 and the RAM is not reading (REQ-015), lane i SHALL store wr_data[i] at wr_addr iff wr_mask[i]=1; other lanes unchanged.
REQ-011 FSM states SHALL be IDLE, RD, CAP, STREAM, FIN.
REQ-012 IDLE: start=1 with row_count>0 SHALL latch start_addr and row_count, assert busy next cycle, go to RD; start with row_count=0 SHALL go to FIN with no output.
REQ-013 start while not in IDLE SHALL be ignored.
REQ-014 RD: SHALL present the current row address to all lane RAMs as a read; next state CAP.
REQ-015 RD with wr_en=1: the write SHALL win the RAM port, the read SHALL not be issued, FSM SHALL stay in RD; in all other states writes proceed normally.
REQ-016 CAP: SHALL copy all LANES RAM outputs into a row buffer, reset lane index to 0, go to STREAM.
REQ-017 STREAM: out_valid=1, out_data=row_buffer[lane index]; on out_valid&out_ready the lane index SHALL increment.
REQ-018 out_data, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 On accepting lane LANES-1: if rows remain, SHALL advance row address and go to RD; else go to FIN.
REQ-020 out_last SHALL be 1 only with lane index LANES-1 of the final row.
REQ-021 Row address SHALL advance modulo DEPTH (DEPTH-1 -> 0).
REQ-022 FIN: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
REQ-023 Latency: start accepted in cycle 0 -> first out_valid in cycle 3 (no write conflict); 2-cycle bubble between rows.
REQ-024 Writes to a row already captured SHALL not affect data already in the row buffer.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, out_valid=0, out_last=0, busy=0, done=0, lane index=0, row counters=0, including mid-drain.
REQ-026 RAM contents SHALL not be cleared by reset.
REQ-027 out_data SHALL be 0 during and after reset until the first CAP.

Structure
REQ-028 Package write_bank_pkg SHALL hold the FSM state enum typedef and default LANES/DEPTH/DATA_W constants.
REQ-029 Each lane SHALL instance sub-module bank_ram (single-port, DEPTH x DATA_W, synchronous 1-cycle read, write-enable).
REQ-030 Row buffer, lane index, row address and remaining-row counter SHALL be registers in the top module.

Verification (LANES=4, DEPTH=8, DATA_W=8)
REQ-031 Write row 2 = {0x13,0x12,0x11,0x10} mask 4'hF; start addr 2 count 1, out_ready=1 -> out_valid in cycles 3..6 data 0x10,0x11,0x12,0x13, out_last on 0x13, done cycle 7.
REQ-032 Rows 7 and 0 preloaded; start addr 7 count 2 -> row 7 lanes then row 0 lanes, 2-cycle bubble between, wrap correct.
REQ-033 Mask 4'b0101 write 0xFF over row of 0x00 -> drain yields 0xFF,0x00,0xFF,0x00.
REQ-034 out_ready low 5 cycles on lane 1 -> out_data held stable, no lane skipped or duplicated.
REQ-035 wr_en held 3 cycles during RD -> writes committed, RD held 3 cycles, drained row reflects the write if same address.
REQ-036 rst_n low mid-STREAM -> next cycle out_valid=0, busy=0, done=0; row_count=0 start -> done pulse, no out_valid.
